pipe_ctrl: RTL and testbench

//  Y86-64 pipeline control unit: generates stall/bubble controls for F, D, E, M, W pipeline registers.

---
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard-driven stall/bubble generation, run/drain/halt
// status tracking and saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic             clr_cnt,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             cpu_halted,
    output logic [2:0]       halt_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    state_t           r_state;
    logic [2:0]       r_halt_stat;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic w_lu;
    logic w_ret;
    logic w_misp;
    logic w_exc_m;
    logic w_exc_w;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1))
            return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        w_lu    = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        w_ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        w_misp  = (E_icode == I_JXX) && !e_Cnd;
        w_exc_m = is_exc(m_stat);
        w_exc_w = is_exc(W_stat);
    end

    // Reset flushes the pipe regardless of FSM state; HALT freezes fetch and retire.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        if (rst_n) begin
            if (r_state == ST_HALT) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b0;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end else begin
                F_stall  = w_lu | w_ret;
                D_stall  = w_lu;
                D_bubble = w_misp | (w_ret & ~w_lu);
                E_bubble = w_misp | w_lu;
                M_bubble = w_exc_m | w_exc_w | (r_state == ST_DRAIN);
                W_stall  = w_exc_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_halt_stat   <= STAT_AOK;
            r_cyc_cnt     <= '0;
            r_stall_cnt   <= '0;
            r_bubble_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_exc_w) begin
                        r_state     <= ST_HALT;
                        r_halt_stat <= W_stat;
                    end else if (w_exc_m) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_exc_w) begin
                        r_state     <= ST_HALT;
                        r_halt_stat <= W_stat;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase

            if (clr_cnt) begin
                r_cyc_cnt     <= '0;
                r_stall_cnt   <= '0;
                r_bubble_cnt  <= '0;
                r_mispred_cnt <= '0;
            end else if (r_state != ST_HALT) begin
                r_cyc_cnt     <= sat_inc(r_cyc_cnt, 1'b1);
                r_stall_cnt   <= sat_inc(r_stall_cnt, F_stall);
                r_bubble_cnt  <= sat_inc(r_bubble_cnt, D_bubble | E_bubble);
                r_mispred_cnt <= sat_inc(r_mispred_cnt, w_misp);
            end
        end
    end

    assign cpu_halted  = (r_state == ST_HALT);
    assign halt_stat   = r_halt_stat;
    assign cyc_cnt     = r_cyc_cnt;
    assign stall_cnt   = r_stall_cnt;
    assign bubble_cnt  = r_bubble_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/exception/counter scenarios checked every
// cycle against a behavioural model, plus literal expectations per scenario.
module tb_pipe_ctrl;

    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic          e_Cnd;
    logic [2:0]    m_stat, W_stat;
    logic          clr_cnt;
    logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic          cpu_halted;
    logic [2:0]    halt_stat;
    logic [CW-1:0] cyc_cnt, stall_cnt, bubble_cnt, mispred_cnt;

    pipe_ctrl #(.CNT_W(CW), .RNONE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .clr_cnt(clr_cnt),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .cpu_halted(cpu_halted), .halt_stat(halt_stat),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    // Model state: mode 0=running, 1=draining, 2=halted.
    int m_mode;
    int m_hs;
    int m_cyc, m_stall, m_bub, m_misp;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit exc(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4);
    endfunction

    // Returns {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}.
    function automatic logic [5:0] model_ctrl();
        bit lu, rt, mp;
        if (!rst_n) return 6'b001110;
        if (m_mode == 2) return 6'b110011;
        lu = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mp = (E_icode == 4'h7) && !e_Cnd;
        return {lu | rt, lu, mp | (rt & !lu), mp | lu,
                exc(m_stat) | exc(W_stat) | (m_mode == 1), exc(W_stat)};
    endfunction

    function automatic int bump(input int v, input bit en);
        return (en && v < MAXC) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        logic [5:0] c;
        c = model_ctrl();
        if (!rst_n) begin
            m_mode = 0; m_hs = 1;
            m_cyc = 0; m_stall = 0; m_bub = 0; m_misp = 0;
        end else begin
            if (clr_cnt) begin
                m_cyc = 0; m_stall = 0; m_bub = 0; m_misp = 0;
            end else if (m_mode != 2) begin
                m_cyc   = bump(m_cyc, 1'b1);
                m_stall = bump(m_stall, c[5]);
                m_bub   = bump(m_bub, c[3] | c[2]);
                m_misp  = bump(m_misp, (E_icode == 4'h7) && !e_Cnd);
            end
            if (m_mode != 2) begin
                if (exc(W_stat)) begin
                    m_mode = 2; m_hs = int'(W_stat);
                end else if (m_mode == 0 && exc(m_stat)) begin
                    m_mode = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (run_cmp) begin
            e = model_ctrl();
            chk("F_stall", F_stall, e[5]);
            chk("D_stall", D_stall, e[4]);
            chk("D_bubble", D_bubble, e[3]);
            chk("E_bubble", E_bubble, e[2]);
            chk("M_bubble", M_bubble, e[1]);
            chk("W_stall", W_stall, e[0]);
            chk("D_stall_and_bubble", int'(D_stall & D_bubble), 0);
            chk("cpu_halted", cpu_halted, (m_mode == 2) ? 1 : 0);
            chk("halt_stat", halt_stat, m_hs);
            chk("cyc_cnt", cyc_cnt, m_cyc);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("bubble_cnt", bubble_cnt, m_bub);
            chk("mispred_cnt", mispred_cnt, m_misp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1;
        M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic set_lu();
        set_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    endtask

    initial begin
        set_idle();
        clr_cnt = 1'b0;
        rst_n   = 1'b0;
        tick();
        run_cmp = 1'b1;
        @(negedge clk);
        chk("rst_flush_F", F_stall, 0);
        chk("rst_flush_Db", D_bubble, 1);
        chk("rst_flush_Mb", M_bubble, 1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cyc", cyc_cnt, 0);
        chk("rst_halt_stat", halt_stat, 1);

        // Load/use
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        set_lu();
        @(negedge clk);
        chk("lu_F", F_stall, 1);
        chk("lu_Ds", D_stall, 1);
        chk("lu_Eb", E_bubble, 1);
        chk("lu_Db", D_bubble, 0);
        tick(); set_idle();
        @(negedge clk);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        chk("lu_cyc_cnt", cyc_cnt, 1);

        // Mispredict with RET in D
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
        @(negedge clk);
        chk("mp_Db", D_bubble, 1);
        chk("mp_Eb", E_bubble, 1);
        chk("mp_F", F_stall, 1);
        tick(); set_idle();
        @(negedge clk);
        chk("mp_mispred_cnt", mispred_cnt, 1);

        // Ret walk D -> E -> M
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            if (i == 0) D_icode = 4'h9;
            if (i == 1) E_icode = 4'h9;
            if (i == 2) M_icode = 4'h9;
            @(negedge clk);
            chk("ret_F", F_stall, 1);
            chk("ret_Db", D_bubble, 1);
            tick();
        end
        set_idle();
        @(negedge clk);
        chk("ret_after_F", F_stall, 0);
        chk("ret_stall_cnt", stall_cnt, 3);
        chk("ret_bubble_cnt", bubble_cnt, 3);

        // Saturation then clear
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        set_lu();
        for (int i = 0; i < MAXC + 7; i++) tick();
        @(negedge clk);
        chk("sat_stall_cnt", stall_cnt, MAXC);
        chk("sat_cyc_cnt", cyc_cnt, MAXC);
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        set_idle();
        @(negedge clk);
        chk("clr_stall_cnt", stall_cnt, 0);
        tick();

        // Exception: m_stat ADR, then W_stat ADR
        m_stat = 3'd3;
        @(negedge clk);
        chk("exc_Mb", M_bubble, 1);
        tick();
        m_stat = 3'd1; W_stat = 3'd3;
        @(negedge clk);
        chk("drain_halted", cpu_halted, 0);
        chk("drain_Ws", W_stall, 1);
        tick();
        W_stat = 3'd1;
        @(negedge clk);
        chk("halt_halted", cpu_halted, 1);
        chk("halt_stat", halt_stat, 3);
        chk("halt_Mb", M_bubble, 1);
        chk("halt_Db", D_bubble, 0);
        chk("halt_cyc_cnt", cyc_cnt, 3);
        set_lu();
        tick(); tick(); tick();
        @(negedge clk);
        chk("halt_frozen_cyc", cyc_cnt, 3);
        chk("halt_frozen_stall", stall_cnt, 0);
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        @(negedge clk);
        chk("halt_clr_cyc", cyc_cnt, 0);
        chk("halt_sticky", cpu_halted, 1);

        // Reset out of HALT
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_F", F_stall, 0);
        chk("rst2_Ws", W_stall, 0);
        chk("rst2_Eb", E_bubble, 1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_halted", cpu_halted, 0);
        chk("rst2_halt_stat", halt_stat, 1);
        chk("rst2_cyc", cyc_cnt, 0);
        tick(); tick();

        run_cmp = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
